// File: rtl/path_switch_feeder.sv
// Path switch feeder: buffers two sample streams, emits aligned pairs with a select bit that toggles every SWAP_PERIOD pairs.
// Optional macro PATH_SWITCH_FEEDER_HOLD_EN adds i_hold_swap to freeze the pair counter and select state.
module path_switch_feeder #(
    parameter int VALUE_WIDTH = 17,
    parameter int FIFO_DEPTH  = 4,
    parameter int SWAP_PERIOD = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [VALUE_WIDTH-1:0] i_in0_data,
    input  logic                   i_in0_valid,
    output logic                   o_in0_ready,
    input  logic [VALUE_WIDTH-1:0] i_in1_data,
    input  logic                   i_in1_valid,
    output logic                   o_in1_ready,
    output logic [VALUE_WIDTH-1:0] o_out0,
    output logic [VALUE_WIDTH-1:0] o_out1,
    output logic                   o_select,
    output logic                   o_valid,
`ifdef PATH_SWITCH_FEEDER_HOLD_EN
    input  logic                   i_hold_swap,
`endif
    input  logic                   i_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PC_W  = (SWAP_PERIOD > 1) ? $clog2(SWAP_PERIOD) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PC_W-1:0]  LAST_PAIR  = PC_W'(SWAP_PERIOD - 1);

    typedef enum logic {SEL0 = 1'b0, SEL1 = 1'b1} sel_state_t;

    logic [VALUE_WIDTH-1:0] in_data [2];
    logic [VALUE_WIDTH-1:0] head_data [2];
    logic [1:0]             in_valid;
    logic [1:0]             fifo_ready;
    logic [1:0]             fifo_not_empty;
    logic                   load;
    logic                   hold;

    logic [VALUE_WIDTH-1:0] out0_reg, out1_reg;
    logic                   select_reg;
    logic                   valid_reg;

    sel_state_t             state_reg, state_next;
    logic [PC_W-1:0]        pair_count_reg, pair_count_next;

    assign in_data[0]  = i_in0_data;
    assign in_data[1]  = i_in1_data;
    assign in_valid    = {i_in1_valid, i_in0_valid};
    assign o_in0_ready = fifo_ready[0];
    assign o_in1_ready = fifo_ready[1];

`ifdef PATH_SWITCH_FEEDER_HOLD_EN
    assign hold = i_hold_swap;
`else
    assign hold = 1'b0;
`endif

    // Both halves pop together so a pair is never split.
    assign load = (&fifo_not_empty) && (!valid_reg || i_ready);

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [VALUE_WIDTH-1:0] mem_reg [FIFO_DEPTH];
        logic [PTR_W-1:0]       wr_ptr_reg;
        logic [PTR_W-1:0]       rd_ptr_reg;
        logic [CNT_W-1:0]       count_reg;
        logic                   push;

        // Ready comes from the count alone: a full FIFO refuses even while popping.
        assign fifo_ready[gi]     = (count_reg != FULL_COUNT);
        assign fifo_not_empty[gi] = (count_reg != '0);
        assign push               = in_valid[gi] && fifo_ready[gi];
        assign head_data[gi]      = mem_reg[rd_ptr_reg];

        always_ff @(posedge i_clk) begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= in_data[gi];
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (load) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                case ({push, load})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= SEL0;
            pair_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pair_count_reg <= pair_count_next;
        end
    end

    // The toggle lands in state_reg, so it only affects the following load.
    always_comb begin
        state_next      = state_reg;
        pair_count_next = pair_count_reg;
        if (load && !hold) begin
            if (pair_count_reg == LAST_PAIR) begin
                pair_count_next = '0;
                state_next      = (state_reg == SEL0) ? SEL1 : SEL0;
            end else begin
                pair_count_next = pair_count_reg + PC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out0_reg   <= '0;
            out1_reg   <= '0;
            select_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else if (load) begin
            out0_reg   <= head_data[0];
            out1_reg   <= head_data[1];
            select_reg <= (state_reg == SEL1);
            valid_reg  <= 1'b1;
        end else if (valid_reg && i_ready) begin
            valid_reg  <= 1'b0;
        end
    end

    assign o_out0   = out0_reg;
    assign o_out1   = out1_reg;
    assign o_select = select_reg;
    assign o_valid  = valid_reg;

endmodule

// File: tb/tb_path_switch_feeder.sv
// Bench for path_switch_feeder: queue-based reference model checked every cycle, plus directed literal expectations.
module tb_path_switch_feeder;

`ifdef PATH_SWITCH_FEEDER_HOLD_EN
    localparam int SP = 2;
`else
    localparam int SP = 4;
`endif
    localparam int VW    = 17;
    localparam int DEPTH = 4;

    typedef struct {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic          s;
        int            cyc;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  = 1'b1;
    logic          v0   = 1'b0;
    logic          v1   = 1'b0;
    logic          rdy  = 1'b0;
    logic          hold = 1'b0;
    logic [VW-1:0] d0   = '0;
    logic [VW-1:0] d1   = '0;

    logic [VW-1:0] o_out0, o_out1;
    logic          o_in0_ready, o_in1_ready, o_select, o_valid;

    path_switch_feeder #(
        .VALUE_WIDTH(VW),
        .FIFO_DEPTH (DEPTH),
        .SWAP_PERIOD(SP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in0_data (d0),
        .i_in0_valid(v0),
        .o_in0_ready(o_in0_ready),
        .i_in1_data (d1),
        .i_in1_valid(v1),
        .o_in1_ready(o_in1_ready),
        .o_out0     (o_out0),
        .o_out1     (o_out1),
        .o_select   (o_select),
        .o_valid    (o_valid),
`ifdef PATH_SWITCH_FEEDER_HOLD_EN
        .i_hold_swap(hold),
`endif
        .i_ready    (rdy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 1'b0;
    bit hold_test = 1'b0;
    int exp_sel[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream driver: pushes n samples base+0..base+n-1 on each channel, holding valid until accepted.
    int   n0 = 0, n1 = 0, sent0 = 0, sent1 = 0, base0 = 0, base1 = 0;
    logic r0_s = 1'b0, r1_s = 1'b0;
    int   mloads = 0;

    always @(posedge clk) begin
        if (v0 && r0_s) sent0++;
        if (v1 && r1_s) sent1++;
        if (rst) begin
            sent0 = 0;
            sent1 = 0;
        end
        #2;
        v0   = !rst && (sent0 < n0);
        v1   = !rst && (sent1 < n1);
        d0   = VW'(base0 + sent0);
        d1   = VW'(base1 + sent1);
        hold = hold_test && (mloads >= 2) && (mloads <= 4);
    end

    // Reference model: two sample queues and one output slot; select derived from the number of counted pairs.
    logic [VW-1:0] q0[$], q1[$];
    logic          mv = 1'b0;
    logic [VW-1:0] m0 = '0, m1 = '0;
    logic          ms = 1'b0;
    int            counted = 0;
    int            cyc = 0;
    pair_t         mlog[$], dut_log[$];

    always @(posedge clk) begin
        bit p0, p1, ld, hs;
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
            mv = 1'b0; m0 = '0; m1 = '0; ms = 1'b0;
            counted = 0;
            mloads  = 0;
        end else begin
            p0 = v0 && (q0.size() < DEPTH);
            p1 = v1 && (q1.size() < DEPTH);
            ld = (q0.size() > 0) && (q1.size() > 0) && (!mv || rdy);
            hs = mv && rdy;
            if (ld) begin
                m0 = q0.pop_front();
                m1 = q1.pop_front();
                ms = ((counted / SP) % 2) == 1;
                if (!hold) counted++;
                mv = 1'b1;
                mlog.push_back('{m0, m1, ms, cyc});
                mloads++;
            end else if (hs) begin
                mv = 1'b0;
            end
            if (p0) q0.push_back(d0);
            if (p1) q1.push_back(d1);
        end
    end

    always @(negedge clk) begin
        r0_s = o_in0_ready;
        r1_s = o_in1_ready;
        if (checking) begin
            chk("cyc o_valid", {31'd0, o_valid}, {31'd0, mv});
            chk("cyc o_in0_ready", {31'd0, o_in0_ready}, {31'd0, q0.size() != DEPTH});
            chk("cyc o_in1_ready", {31'd0, o_in1_ready}, {31'd0, q1.size() != DEPTH});
            chk("cyc o_out0", 32'(o_out0), 32'(m0));
            chk("cyc o_out1", 32'(o_out1), 32'(m1));
            chk("cyc o_select", {31'd0, o_select}, {31'd0, ms});
            if (o_valid && rdy) dut_log.push_back('{o_out0, o_out1, o_select, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        n0  = 0;
        n1  = 0;
        step();
        rst = 1'b0;
        dut_log.delete();
        mlog.delete();
        chk({tag, " rst o_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, " rst o_out0"}, 32'(o_out0), 32'd0);
        chk({tag, " rst o_out1"}, 32'(o_out1), 32'd0);
        chk({tag, " rst o_select"}, {31'd0, o_select}, 32'd0);
        chk({tag, " rst readies"}, {30'd0, o_in1_ready, o_in0_ready}, 32'd3);
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && dut_log.size() < n; i++) step();
    endtask

    task automatic check_log(input string tag, input int n, input int b0, input int b1, input bit chk_cyc);
        chk({tag, " dut pair count"}, dut_log.size(), n);
        chk({tag, " model pair count"}, mlog.size(), n);
        for (int k = 0; k < n && k < dut_log.size(); k++) begin
            chk($sformatf("%s pair%0d out0", tag, k), 32'(dut_log[k].a), b0 + k);
            chk($sformatf("%s pair%0d out1", tag, k), 32'(dut_log[k].b), b1 + k);
            chk($sformatf("%s pair%0d select", tag, k), {31'd0, dut_log[k].s}, exp_sel[k]);
            if (chk_cyc && k > 0)
                chk($sformatf("%s pair%0d cycle gap", tag, k), dut_log[k].cyc - dut_log[k-1].cyc, 1);
        end
        for (int k = 0; k < n && k < mlog.size(); k++) begin
            chk($sformatf("%s model pair%0d out0", tag, k), 32'(mlog[k].a), b0 + k);
            chk($sformatf("%s model pair%0d select", tag, k), {31'd0, mlog[k].s}, exp_sel[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef PATH_SWITCH_FEEDER_HOLD_EN
        exp_sel = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
`else
        exp_sel = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`endif
        step();
        do_reset("init");
        checking = 1'b1;

        // First pair: pushed at edge 1, visible after edge 2.
        rdy = 1'b1; base0 = 'h0ABAB; base1 = 'h0CDCD; n0 = 1; n1 = 1;
        step();
        step();
        chk("first o_valid", {31'd0, o_valid}, 32'd1);
        chk("first o_out0", 32'(o_out0), 32'h0ABAB);
        chk("first o_out1", 32'(o_out1), 32'h0CDCD);
        chk("first o_select", {31'd0, o_select}, 32'd0);
        repeat (2) step();

        // Continuous streams, one pair per cycle.
        do_reset("stream");
        rdy = 1'b1; base0 = 0; base1 = 'h100; n0 = 12; n1 = 12;
        wait_log(12, 40);
        check_log("stream", 12, 0, 'h100, 1'b1);

        // Stream 0 alone fills its FIFO; nothing is emitted until stream 1 arrives.
        do_reset("fill");
        rdy = 1'b1; base0 = 'h10; base1 = 'h20; n0 = 5; n1 = 0;
        repeat (6) step();
        chk("fill in0 ready low", {31'd0, o_in0_ready}, 32'd0);
        chk("fill no pair", {31'd0, o_valid}, 32'd0);
        chk("fill accepted0", sent0, 4);
        n1 = 4;
        wait_log(4, 30);
        check_log("fill", 4, 'h10, 'h20, 1'b0);
        repeat (3) step();
        chk("fill fifth accepted", sent0, 5);
        chk("fill lone waits", {31'd0, o_valid}, 32'd0);
        chk("fill no extra pair", dut_log.size(), 4);

        // Downstream stall: outputs frozen, FIFOs fill, then full delivery.
        do_reset("stall");
        rdy = 1'b0; base0 = 'h30; base1 = 'h40; n0 = 8; n1 = 8;
        repeat (2) step();
        chk("stall o_valid", {31'd0, o_valid}, 32'd1);
        repeat (6) step();
        chk("stall held o_valid", {31'd0, o_valid}, 32'd1);
        chk("stall held o_out0", 32'(o_out0), 32'h30);
        chk("stall held o_out1", 32'(o_out1), 32'h40);
        chk("stall held o_select", {31'd0, o_select}, 32'd0);
        chk("stall readies low", {30'd0, o_in1_ready, o_in0_ready}, 32'd0);
        rdy = 1'b1;
        wait_log(8, 40);
        check_log("stall", 8, 'h30, 'h40, 1'b0);

        // Reset mid-stream with three entries buffered per FIFO.
        do_reset("pre");
        rdy = 1'b0; base0 = 'h50; base1 = 'h58; n0 = 4; n1 = 4;
        repeat (4) step();
        chk("mid o_valid", {31'd0, o_valid}, 32'd1);
        chk("mid o_out0", 32'(o_out0), 32'h50);
        chk("mid accepted", sent0 + sent1, 8);
        do_reset("mid");
        rdy = 1'b1; base0 = 'h70; base1 = 'h78; n0 = 3; n1 = 3;
        wait_log(3, 30);
        check_log("after rst", 3, 'h70, 'h78, 1'b0);

`ifdef PATH_SWITCH_FEEDER_HOLD_EN
        // Hold on pairs 2..4 freezes the select sequence.
        do_reset("hold");
        exp_sel = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
        rdy = 1'b1; base0 = 'h80; base1 = 'h90; n0 = 9; n1 = 9; hold_test = 1'b1;
        wait_log(9, 40);
        hold_test = 1'b0;
        check_log("hold", 9, 'h80, 'h90, 1'b1);
`endif

        repeat (2) step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
